// File: rtl/mul_hilo_sequencer_pkg.sv
// Shared constants and state encoding for the HI/LO multiply sequencer.
package mul_hilo_sequencer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_e;

endpackage

// File: rtl/mul_hilo_sequencer_hilo_regs.sv
// Architectural HI/LO register pair. A product capture takes priority over direct writes.
module mul_hilo_sequencer_hilo_regs
    import mul_hilo_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = mul_hilo_sequencer_pkg::WORD_W
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                cap_en,
    input  logic [2*DATA_W-1:0] cap_data,
    input  logic                hi_wr,
    input  logic                lo_wr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   hi_out,
    output logic [DATA_W-1:0]   lo_out
);

    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // Next-state: capture overrides both strobes on the same edge.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (cap_en) begin
            hi_d = cap_data[2*DATA_W-1:DATA_W];
            lo_d = cap_data[DATA_W-1:0];
        end else begin
            if (hi_wr) begin
                hi_d = wr_data;
            end
            if (lo_wr) begin
                lo_d = wr_data;
            end
        end
    end

    // HI/LO state with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: rtl/mul_hilo_sequencer.sv
// Multi-cycle control around an external combinational multiplier: latches operands,
// waits SETTLE_CYCLES edges for the product to settle, then captures it into HI/LO.
module mul_hilo_sequencer
    import mul_hilo_sequencer_pkg::*;
#(
    parameter int unsigned WORD_W        = mul_hilo_sequencer_pkg::WORD_W,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic [WORD_W-1:0]   op_a,
    input  logic [WORD_W-1:0]   op_b,
    output logic [WORD_W-1:0]   mul_a,
    output logic [WORD_W-1:0]   mul_b,
    input  logic [2*WORD_W-1:0] mul_z,
    input  logic                hi_wr,
    input  logic                lo_wr,
    input  logic [WORD_W-1:0]   wr_data,
    output logic                busy,
    output logic                done,
    output logic [WORD_W-1:0]   hi_out,
    output logic [WORD_W-1:0]   lo_out
);

    // The settle counter is CNT_W bits wide, so only 1..2**CNT_W-1 cycles are representable.
    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > (2 ** CNT_W) - 1)) begin : g_bad_settle
        $error("mul_hilo_sequencer: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  mul_a_q, mul_a_d;
    logic [WORD_W-1:0]  mul_b_q, mul_b_d;
    logic               done_q, done_d;
    logic               cap_en;

    // Next-state: accept start only in IDLE, count down in SETTLE, capture when count hits 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        done_d  = 1'b0;
        cap_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mul_a_d = op_a;
                    mul_b_d = op_b;
                    cnt_d   = CNT_INIT;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cap_en  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state; clear abandons any in-flight multiply.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            done_q  <= done_d;
        end
    end

    mul_hilo_sequencer_hilo_regs #(
        .DATA_W (WORD_W)
    ) u_hilo_regs (
        .clock    (clock),
        .clear    (clear),
        .cap_en   (cap_en),
        .cap_data (mul_z),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wr_data  (wr_data),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;
    assign busy  = (state_q == S_SETTLE);
    assign done  = done_q;

endmodule

// File: doc/mul_hilo_sequencer.md
Name: mul_hilo_sequencer

Overview:
Multi-cycle control stage wrapped around the combinational 32x32 signed Booth multiplier. It latches operands on a start pulse and drives them to the multiplier. It waits a fixed number of cycles for the multiplier's long combinational path to settle, then captures the 64-bit product into the architectural HI/LO registers. It also services direct HI/LO writes (mthi/mtlo) and exposes HI/LO to the datapath bus.

Parameters:
WORD_W, 32, operand width and HI/LO register width.
SETTLE_CYCLES, 2, cycles the multiplier output is allowed to settle before capture; legal range 1..15.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
clear  in  1  synchronous, active-high reset.
start  in  1  request a multiply; sampled only in IDLE.
op_a  in  WORD_W  signed multiplicand.
op_b  in  WORD_W  signed multiplier.
mul_a  out  WORD_W  registered operand driven to the multiplier's a input.
mul_b  out  WORD_W  registered operand driven to the multiplier's b input.
mul_z  in  2*WORD_W  product returned by the multiplier.
hi_wr  in  1  direct write strobe for HI.
lo_wr  in  1  direct write strobe for LO.
wr_data  in  WORD_W  data for hi_wr/lo_wr.
busy  out  1  high while a multiply is in flight.
done  out  1  one-cycle pulse; HI/LO hold the new product.
hi_out  out  WORD_W  current HI (product bits 63:32).
lo_out  out  WORD_W  current LO (product bits 31:0).

Behaviour:
- Reset: clock/clear are the codebase's names; reset is synchronous, active-high.
  - Values when clear=1 at an edge: state=IDLE, cnt=0, mul_a=mul_b=0, hi_out=lo_out=0, busy=0, done=0.
  - clear overrides every other input, including an in-flight multiply, which is abandoned with no capture.
- FSM has two states, IDLE and SETTLE. busy = (state==SETTLE), combinational from the state register.
- IDLE, start=1 at edge E0:
  - mul_a<=op_a, mul_b<=op_b.
  - cnt<=SETTLE_CYCLES-1; state<=SETTLE.
- SETTLE, each edge:
  - cnt!=0: cnt<=cnt-1; mul_a/mul_b hold.
  - cnt==0: hi_out<=mul_z[63:32], lo_out<=mul_z[31:0], done<=1, state<=IDLE.
- Latency: capture occurs at edge E0+SETTLE_CYCLES; done is high for exactly the following cycle. Default latency is 2 edges after the start edge.
- done is a registered pulse; it deasserts at the next edge unless a new capture occurs.
- start while in SETTLE is ignored and not queued. A start in the cycle where done=1 is accepted, because state is already IDLE.
- mul_a/mul_b hold their last values in IDLE; they are not cleared after capture.
- Direct writes:
  - hi_wr=1 loads HI from wr_data; lo_wr=1 loads LO from wr_data.
  - Both strobes together load both registers with the same value.
  - Accepted in any state.
  - In the same edge as a capture, the capture wins for both registers and the direct write is dropped.
  - A direct write during SETTLE without capture takes effect and is later overwritten by the capture.
- No arithmetic in this block. The product is taken verbatim from mul_z; the sign is carried by the multiplier.
- cnt width is 4 bits. SETTLE_CYCLES outside 1..15 is a static configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared CPU package holds:
  - WORD_W constant.
  - State encoding constants S_IDLE=1'b0, S_SETTLE=1'b1.
- No sub-module is needed. The HI/LO pair with its write-priority mux may be factored as hilo_regs (clock, clear, cap_en, cap_data[63:0], hi_wr, lo_wr, wr_data, hi_out, lo_out) if the register file reuses it.
- The Booth multiplier is instantiated beside this block in the datapath, not inside it.

Test Plan:
1. Reset then idle: clear=1 for 2 cycles -> hi_out=lo_out=0, busy=0, done=0. Clear mid-SETTLE -> no done pulse, HI/LO=0.
2. start with op_a=7, op_b=-3 (0xFFFFFFFD), multiplier attached -> busy for 2 cycles, done pulse on the 3rd cycle, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. op_a=op_b=0x80000000 -> HI=0x40000000, LO=0x00000000. Also op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> HI=0, LO=1.
4. start re-asserted every cycle while busy -> exactly one capture. A start in the done cycle with op_a=5, op_b=6 -> second done 2 edges later, LO=30, HI=0.
5. hi_wr=1 with wr_data=0xDEADBEEF in IDLE -> hi_out=0xDEADBEEF next cycle, LO unchanged. hi_wr+lo_wr on the capture edge of 2x3 -> HI=0, LO=6.
6. SETTLE_CYCLES=1 build: start at E0 -> capture at E1, done high the cycle after E1.
